// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - data RAM plus MMIO page (GPIO, timer/compare, status, write counter)
module dmem_mmio_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [19:0] MMIO_PAGE   = 20'h00001,
   parameter int          GPIO_W      = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              MemWrite,
   input  logic [31:0]       ALUResult,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // MMIO register word offsets (byte offset >> 2)
   localparam logic [9:0] OFF_GPIO_OUT = 10'h000;
   localparam logic [9:0] OFF_GPIO_IN  = 10'h001;
   localparam logic [9:0] OFF_MTIME    = 10'h002;
   localparam logic [9:0] OFF_MTIMECMP = 10'h003;
   localparam logic [9:0] OFF_STATUS   = 10'h004;
   localparam logic [9:0] OFF_WRCOUNT  = 10'h005;

   // Address decode; byte offset bits never select data, only flag misalignment
   logic          mmio_sel;
   logic [9:0]    woff;
   logic [AW-1:0] ram_idx;
   logic          ram_we;
   logic          mmio_we;
   logic          misalign;

   assign mmio_sel = (ALUResult[31:12] == MMIO_PAGE);
   assign woff     = ALUResult[11:2];
   assign ram_idx  = ALUResult[AW+1:2];
   assign ram_we   = MemWrite & ~mmio_sel;
   assign mmio_we  = MemWrite & mmio_sel;
   assign misalign = MemWrite & (|ALUResult[1:0]);

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] sync1_q, sync2_q;
   logic [31:0]       mtime_q, mtime_d;
   logic [31:0]       mtimecmp_q, mtimecmp_d;
   logic [1:0]        status_q, status_d;
   logic [1:0]        status_set, status_clr;
   logic [31:0]       wrcount_q, wrcount_d;
   logic [31:0]       rdata;

   // RAM write port; contents deliberately not reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[ram_idx] <= WriteData;
      end
   end

   // Next-state for MMIO registers; a register write beats the timer increment,
   // and a status set beats a same-cycle write-1-to-clear
   always_comb begin
      gpio_out_d = gpio_out_q;
      mtime_d    = mtime_q + 32'd1;
      mtimecmp_d = mtimecmp_q;
      status_clr = 2'b00;
      wrcount_d  = wrcount_q;
      if (mmio_we) begin
         case (woff)
            OFF_GPIO_OUT: gpio_out_d = WriteData[GPIO_W-1:0];
            OFF_MTIME:    mtime_d    = WriteData;
            OFF_MTIMECMP: mtimecmp_d = WriteData;
            OFF_STATUS:   status_clr = WriteData[1:0];
            default:      ;
         endcase
      end
      // compare uses registered values, never the data being written
      status_set = {misalign, (mtime_q == mtimecmp_q)};
      status_d   = status_set | (status_q & ~status_clr);
      if (ram_we && (wrcount_q != 32'hFFFF_FFFF)) begin
         wrcount_d = wrcount_q + 32'd1;
      end
   end

   // MMIO state and gpio_in synchronizer, asynchronously cleared
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         mtime_q    <= 32'h0;
         mtimecmp_q <= 32'hFFFF_FFFF;
         status_q   <= 2'b00;
         wrcount_q  <= 32'h0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         status_q   <= status_d;
         wrcount_q  <= wrcount_d;
      end
   end

   // Zero-latency read mux; same-cycle writes are not forwarded
   always_comb begin
      rdata = 32'h0;
      if (mmio_sel) begin
         case (woff)
            OFF_GPIO_OUT: rdata = 32'(gpio_out_q);
            OFF_GPIO_IN:  rdata = 32'(sync2_q);
            OFF_MTIME:    rdata = mtime_q;
            OFF_MTIMECMP: rdata = mtimecmp_q;
            OFF_STATUS:   rdata = {30'h0, status_q};
            OFF_WRCOUNT:  rdata = wrcount_q;
            default:      rdata = 32'h0;
         endcase
      end else begin
         rdata = mem_q[ram_idx];
      end
   end

   assign ReadData  = rdata;
   assign gpio_out  = gpio_out_q;
   assign timer_irq = status_q[0];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - scoreboard bench for dmem_mmio_responder
module tb_dmem_mmio_responder;

   localparam logic [31:0] A_GPIO_OUT = 32'h0000_1000;
   localparam logic [31:0] A_GPIO_IN  = 32'h0000_1004;
   localparam logic [31:0] A_MTIME    = 32'h0000_1008;
   localparam logic [31:0] A_MTIMECMP = 32'h0000_100C;
   localparam logic [31:0] A_STATUS   = 32'h0000_1010;
   localparam logic [31:0] A_WRCOUNT  = 32'h0000_1014;
   localparam logic [31:0] A_UNMAP    = 32'h0000_1020;

   logic        clk;
   logic        n_rst;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   dmem_mmio_responder #(
      .DEPTH_WORDS(256),
      .MMIO_PAGE  (20'h00001),
      .GPIO_W     (8)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .MemWrite (MemWrite),
      .ALUResult(ALUResult),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .timer_irq(timer_irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic pop_cmp();
      exp_t x;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         x = sb_q.pop_front();
         chk(x.tag, ReadData, x.exp);
      end
   endtask

   // combinational read: push expectation, let the mux settle, compare
   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
      MemWrite  = 1'b0;
      ALUResult = a;
      sb_q.push_back('{tag, e});
      #1;
      pop_cmp();
   endtask

   // one-cycle write; returns at the negedge after the commit edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ALUResult = a;
      WriteData = d;
      MemWrite  = 1'b1;
      @(negedge clk);
      MemWrite  = 1'b0;
   endtask

   // write that also checks the same-cycle read returns the old word
   task automatic wr_old(input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] old, input string tag);
      ALUResult = a;
      WriteData = d;
      MemWrite  = 1'b1;
      sb_q.push_back('{tag, old});
      #1;
      pop_cmp();
      @(negedge clk);
      MemWrite  = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_rst     = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = 32'h0;
      WriteData = 32'h0;
      gpio_in   = 8'h00;
      @(negedge clk);

      // reset state
      rd(A_MTIME,    32'h0,         "rst_mtime");
      rd(A_MTIMECMP, 32'hFFFF_FFFF, "rst_mtimecmp");
      rd(A_STATUS,   32'h0,         "rst_status");
      rd(A_WRCOUNT,  32'h0,         "rst_wrcount");
      rd(A_GPIO_OUT, 32'h0,         "rst_gpio_out");
      chk("rst_irq", {31'd0, timer_irq}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // RAM write, read-back, write count, alias
      wr(32'h40, 32'hDEAD_BEEF);
      rd(32'h40,    32'hDEAD_BEEF, "ram_rd");
      rd(A_WRCOUNT, 32'd1,         "wrcount_1");
      rd(32'h440,   32'hDEAD_BEEF, "ram_alias");

      // misaligned write lands on aligned word, read in write cycle sees old data
      wr_old(32'h43, 32'h1122_3344, 32'hDEAD_BEEF, "ram_old_same_cycle");
      rd(32'h40,    32'h1122_3344, "misalign_data");
      rd(A_STATUS,  32'd2,         "misalign_flag");
      wr(A_STATUS, 32'd2);
      rd(A_STATUS,  32'd0,         "misalign_w1c");
      rd(A_WRCOUNT, 32'd2,         "wrcount_2");

      // timer compare: irq rises 11 edges after MTIME write edge
      wr(A_MTIME, 32'd0);
      wr(A_MTIMECMP, 32'd100);
      wr(A_MTIME, 32'd90);
      rd(A_MTIME, 32'd90, "mtime_wr");
      for (int k = 1; k <= 11; k++) begin
         step(1);
         rd(A_MTIME, 32'd90 + k, "mtime_cnt");
         chk("irq_rise", {31'd0, timer_irq}, (k >= 11) ? 32'd1 : 32'd0);
      end

      // clear issued during the equality cycle: set wins
      wr(A_MTIMECMP, 32'd105);
      rd(A_MTIME, 32'd102, "mtime_pre_eq");
      step(3);
      rd(A_MTIME, 32'd105, "mtime_eq");
      wr(A_STATUS, 32'd1);
      chk("irq_set_wins", {31'd0, timer_irq}, 32'd1);
      rd(A_STATUS, 32'd1, "status_set_wins");
      wr(A_STATUS, 32'd1);
      chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
      rd(A_STATUS, 32'd0, "status_cleared");

      // MTIME wrap and write priority over increment
      wr(A_MTIME, 32'hFFFF_FFFE);
      rd(A_MTIME, 32'hFFFF_FFFE, "wrap_0");
      step(1);
      rd(A_MTIME, 32'hFFFF_FFFF, "wrap_1");
      step(1);
      rd(A_MTIME, 32'h0, "wrap_2");
      step(1);
      rd(A_MTIME, 32'h1, "wrap_3");
      wr(A_MTIME, 32'd5);
      rd(A_MTIME, 32'd5, "mtime_wr_prio");

      // GPIO out, synchronized GPIO in, unmapped offset
      wr(A_GPIO_OUT, 32'hFFFF_FFA5);
      chk("gpio_out_pin", {24'd0, gpio_out}, 32'h0000_00A5);
      rd(A_GPIO_OUT, 32'h0000_00A5, "gpio_out_rd");
      gpio_in = 8'h3C;
      rd(A_GPIO_IN, 32'h0, "gpio_in_0edge");
      step(1);
      rd(A_GPIO_IN, 32'h0, "gpio_in_1edge");
      step(1);
      rd(A_GPIO_IN, 32'h3C, "gpio_in_2edge");
      rd(A_UNMAP, 32'h0, "unmap_rd");
      wr(A_UNMAP, 32'hDEAD_BEEF);
      rd(A_UNMAP,    32'h0,         "unmap_after_wr");
      rd(A_GPIO_OUT, 32'h0000_00A5, "unmap_no_side");
      rd(A_WRCOUNT,  32'd2,         "wrcount_mmio_uncounted");

      // build STATUS=3 (compare equality created by a write, misaligned MMIO write)
      wr(A_MTIMECMP, 32'd1000);
      wr(A_MTIME, 32'd1000);
      wr(A_GPIO_OUT + 32'd1, 32'h0000_00A5);
      wr(A_MTIME, 32'd1234);
      rd(A_MTIME,    32'd1234,      "pre_rst_mtime");
      rd(A_STATUS,   32'd3,         "pre_rst_status");
      rd(A_GPIO_OUT, 32'h0000_00A5, "pre_rst_gpio");
      chk("pre_rst_irq", {31'd0, timer_irq}, 32'd1);

      // asynchronous reset mid-cycle
      #2;
      n_rst = 1'b0;
      #1;
      rd(A_MTIME,    32'h0,         "async_rst_mtime");
      rd(A_STATUS,   32'h0,         "async_rst_status");
      rd(A_GPIO_OUT, 32'h0,         "async_rst_gpio");
      rd(A_MTIMECMP, 32'hFFFF_FFFF, "async_rst_mtimecmp");
      chk("async_rst_irq", {31'd0, timer_irq}, 32'd0);
      chk("async_rst_gpio_pin", {24'd0, gpio_out}, 32'd0);
      rd(32'h40, 32'h1122_3344, "ram_survives_rst");
      n_rst = 1'b1;
      step(1);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-side memory responder for the single-cycle RISC-V core.
- Sits on the core's MemWrite / ALUResult / WriteData / ReadData interface.
- Serves word reads combinationally in the same cycle, and commits writes on the clock edge.
- Contains a word-addressed data RAM plus one MMIO page: GPIO, free-running timer with compare/interrupt, sticky status and a RAM write counter.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words; power of two, 16..4096.
- MMIO_PAGE, 20'h00001, value of addr[31:12] that selects the MMIO page.
- GPIO_W, 8, width of gpio_out and gpio_in.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- MemWrite  input  1  write strobe from the core; a write commits at the next rising edge.
- ALUResult  input  32  byte address from the core.
- WriteData  input  32  write data from the core.
- ReadData  output  32  read data; combinational from ALUResult in the same cycle.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  GPIO output register.
- timer_irq  output  1  equals STATUS[0] (timer pending).

Behaviour:
- Clock is clk, reset is n_rst, asynchronous active-low; all registers clear immediately on n_rst=0.
- RAM contents are not reset.

Decode:
- MMIO is selected when addr[31:12]==MMIO_PAGE; otherwise the access goes to RAM.
- RAM index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits alias (wrap) silently.

Alignment:
- addr[1:0] is ignored for data; the access is always a full word.
- If addr[1:0]!=0 while MemWrite=1, STATUS[1] (misalign_err) sets at the edge, and the write still proceeds to the aligned word.

Read path:
- ReadData is purely combinational, with zero latency.
- A read of an address being written in the same cycle returns the old contents.
- Unmapped MMIO offsets read 32'h0.

Write path:
- A write takes effect at the rising edge where MemWrite=1.

MMIO map (offset = addr[11:0]; writes to RO or unmapped offsets are ignored):
- 0x000 GPIO_OUT, RW, bits [GPIO_W-1:0], reset 0. Upper bits read 0.
- 0x004 GPIO_IN, RO. gpio_in passes through a 2-flop synchronizer (reset 0), so reads reflect the input 2 cycles late.
- 0x008 MTIME, RW, reset 0.
  - Increments by 1 every cycle and wraps 32'hFFFFFFFF to 0.
  - A write has priority over the increment: the next value equals WriteData, then counting resumes from it.
- 0x00C MTIMECMP, RW, reset 32'hFFFFFFFF.
- 0x010 STATUS, reset 0.
  - bit0 timer_pending; bit1 misalign_err; other bits read 0.
  - Write-1-to-clear per bit.
  - Set condition and clear in the same cycle: set wins.
  - timer_pending sets at the edge following any cycle where the registered MTIME==MTIMECMP. This includes equality created by writing either register: the compare uses the current register values, not the written data.
- 0x014 WRCOUNT, RO, reset 0.
  - Counts RAM writes only (MMIO writes are not counted).
  - Saturates at 32'hFFFFFFFF.

Other rules:
- timer_irq = STATUS[0], registered; it does not self-clear.
- Reset asserted mid-operation: all MMIO registers and the synchronizer return to reset values asynchronously. A write in flight at that edge is dropped for MMIO registers; the RAM write outcome is undefined.

Test Plan:
- Reset → RAM write/read:
  - Reset, then write 32'hDEADBEEF to 0x40 (MemWrite=1, one cycle).
  - Same cycle ReadData=old/X; next cycle a read of 0x40 returns 32'hDEADBEEF.
  - WRCOUNT reads 1.
  - With DEPTH_WORDS=256, a read of 0x440 returns 32'hDEADBEEF (wrap alias).
- Misaligned write:
  - Write 32'h11223344 to 0x43.
  - A read of 0x40 returns 32'h11223344; STATUS reads 2.
  - Writing STATUS=2 clears it to 0.
- Timer compare:
  - Write MTIMECMP=100, then MTIME=90.
  - MTIME reads 90+k after k cycles.
  - timer_irq rises exactly 11 cycles after the MTIME write edge.
  - Writing STATUS=1 drops timer_irq on the following edge.
  - Write STATUS=1 in the same cycle that MTIME==MTIMECMP → timer_irq stays 1 (set wins).
- MTIME wrap and write priority:
  - Write MTIME=32'hFFFFFFFE.
  - Reads show FFFFFFFF, then 0, then 1.
  - Writing MTIME=5 reads 5 on the next cycle, not 6.
- GPIO and unmapped:
  - Write GPIO_OUT=32'hFFFF_FFA5 → gpio_out=8'hA5 and a read returns 32'h000000A5.
  - Drive gpio_in=8'h3C → a GPIO_IN read shows 8'h3C from the 2nd edge after the change, not earlier.
  - A read of offset 0x020 returns 0; a write to it changes nothing.
- Reset mid-operation:
  - Pulse n_rst low asynchronously (between edges) with MTIME=1234, STATUS=3, GPIO_OUT=A5.
  - All three read as 0 immediately, with MTIMECMP=FFFFFFFF and timer_irq=0.
  - RAM word 0x40 remains 32'h11223344.
